// File: rtl/neuron_pkg.sv
// Shared widths, defaults and state encoding for the neuron training controller.
package neuron_pkg;
  localparam int FINAL_W        = 23;
  localparam int LOSS_W         = 46;
  localparam int WEIGHTS_W      = 64;
  localparam int NUM_LANES      = 8;
  localparam int VEC_W          = 8;
  localparam int MAX_EPOCHS_DEF = 15;
  localparam int W_STEP_DEF     = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_FWD1, S_FWD2, S_EVAL, S_UPDATE, S_DONE
  } state_t;
endpackage

// File: rtl/neuron_train_ctrl_if.sv
// Serial weight-load handshake between a config source and the controller.
interface neuron_train_ctrl_if;
  import neuron_pkg::*;
  logic             cfg_valid_i;
  logic [VEC_W-1:0] cfg_data_i;
  logic             cfg_ready_o;

  modport master (output cfg_valid_i, cfg_data_i, input cfg_ready_o);
  modport slave  (input cfg_valid_i, cfg_data_i, output cfg_ready_o);
endinterface

// File: rtl/weight_step_sat.sv
// Per-lane saturating add/subtract of a fixed step, carried out in 9 bits
// so the carry/borrow bit selects the clamp value.
module weight_step_sat
  import neuron_pkg::*;
#(
  parameter int W_STEP = W_STEP_DEF
) (
  input  logic [NUM_LANES-1:0][VEC_W-1:0] w,
  input  logic                            dec,
  output logic [NUM_LANES-1:0][VEC_W-1:0] w_next
);
  localparam logic [VEC_W:0] STEP = (VEC_W+1)'(W_STEP);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [VEC_W:0] ext, sum, dif;
    assign ext = {1'b0, w[i]};
    assign sum = ext + STEP;
    assign dif = ext - STEP;
    assign w_next[i] = dec ? (dif[VEC_W] ? '0 : dif[VEC_W-1:0])
                           : (sum[VEC_W] ? '1 : sum[VEC_W-1:0]);
  end
endmodule

// File: rtl/neuron_train_ctrl.sv
// Training loop controller: loads 8 weights, runs clear/forward/evaluate
// passes against a neuron and nudges weights toward the target.
module neuron_train_ctrl
  import neuron_pkg::*;
#(
  parameter int MAX_EPOCHS = MAX_EPOCHS_DEF,
  parameter int W_STEP     = W_STEP_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [3:0]           target_i,
  neuron_train_ctrl_if.slave   cfg,
  input  logic [FINAL_W-1:0]   final_i,
  input  logic [LOSS_W-1:0]    loss_i,
  output logic                 en_o,
  output logic                 zero_final_o,
  output logic                 zero_loss_o,
  output logic [WEIGHTS_W-1:0] weights_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 converged_o,
  output logic [7:0]           epoch_o,
  output logic [LOSS_W-1:0]    last_loss_o
);
  localparam logic [7:0] LAST_EPOCH = 8'(MAX_EPOCHS - 1);

  state_t                          state, next;
  logic [2:0]                      idx;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_q, w_step;
  logic [3:0]                      target_q;
  logic [FINAL_W-1:0]              final_q;
  logic                            hit, dec;

  assign hit       = (final_i == FINAL_W'(target_q));
  // Direction comes from the result captured in EVAL, not the live input.
  assign dec       = (final_q > FINAL_W'(target_q));
  assign weights_o = w_q;

  weight_step_sat #(.W_STEP(W_STEP)) u_step (
    .w(w_q), .dec(dec), .w_next(w_step)
  );

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= S_IDLE;
    else        state <= next;

  always_comb begin
    next            = state;
    cfg.cfg_ready_o = 1'b0;
    en_o            = 1'b0;
    zero_final_o    = 1'b0;
    zero_loss_o     = 1'b0;
    case (state)
      S_IDLE:   if (start_i) next = S_LOAD;
      S_LOAD: begin
        cfg.cfg_ready_o = 1'b1;
        if (cfg.cfg_valid_i && idx == 3'd7) next = S_CLEAR;
      end
      S_CLEAR: begin
        zero_final_o = 1'b1;
        zero_loss_o  = 1'b1;
        next         = S_FWD1;
      end
      S_FWD1:   begin en_o = 1'b1; next = S_FWD2; end
      S_FWD2:   begin en_o = 1'b1; next = S_EVAL; end
      S_EVAL:   next = (hit || epoch_o == LAST_EPOCH) ? S_DONE : S_UPDATE;
      S_UPDATE: next = S_CLEAR;
      S_DONE:   next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx         <= '0;
      w_q         <= '0;
      target_q    <= '0;
      final_q     <= '0;
      epoch_o     <= '0;
      last_loss_o <= '0;
      converged_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      busy_o <= (next != S_IDLE);
      done_o <= (next == S_DONE);
      case (state)
        S_IDLE: if (start_i) begin
          target_q    <= target_i;
          epoch_o     <= '0;
          converged_o <= 1'b0;
          idx         <= '0;
        end
        S_LOAD: if (cfg.cfg_valid_i) begin
          w_q[idx] <= cfg.cfg_data_i;
          idx      <= idx + 3'd1;
        end
        S_EVAL: begin
          last_loss_o <= loss_i;
          final_q     <= final_i;
          if (hit) converged_o <= 1'b1;
        end
        S_UPDATE: begin
          w_q <= w_step;
          if (epoch_o != LAST_EPOCH) epoch_o <= epoch_o + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
